// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: select codes, shadow-slot records and default widths
package fwd_hazard_ctrl_pkg;
  localparam int REG_AW = 4;
  localparam int CNT_W = 16;
  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB = 2'b10;
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] dest;
    logic wb_en;
    logic mem_r_en;
  } slot_t;
  typedef struct packed {
    logic [REG_AW-1:0] src1;
    logic src1_en;
    logic [REG_AW-1:0] src2;
    logic src2_en;
  } src_t;
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID decode info, pipeline control lines and forwarding/stall outputs
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W = 16
);
  logic freeze;
  logic flush;
  logic id_valid;
  logic [REG_AW-1:0] id_src1;
  logic id_src1_en;
  logic [REG_AW-1:0] id_src2;
  logic id_two_src;
  logic [REG_AW-1:0] id_dest;
  logic id_wb_en;
  logic id_mem_r_en;
  logic hazard;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output freeze, flush, id_valid, id_src1, id_src1_en, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en,
    input hazard, sel_src1, sel_src2, stall_cnt
  );
  modport slave (
    input freeze, flush, id_valid, id_src1, id_src1_en, id_src2, id_two_src,
          id_dest, id_wb_en, id_mem_r_en,
    output hazard, sel_src1, sel_src2, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// fwd_match: does a shadow slot produce the register a source operand reads
module fwd_match #(
  parameter int REG_AW = 4
) (
  input logic valid,
  input logic wb_en,
  input logic [REG_AW-1:0] dest,
  input logic [REG_AW-1:0] src,
  input logic en,
  output logic match
);
  assign match = valid && wb_en && dest == src && en;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EXE forwarding selects and load-use stall; FWD_HAZARD_FORWARDING_EN enables forwarding
module fwd_hazard_ctrl #(
  parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
  parameter int CNT_W = fwd_hazard_ctrl_pkg::CNT_W
) (
  input logic clk,
  input logic rst,
  fwd_hazard_ctrl_if.slave bus
);
  import fwd_hazard_ctrl_pkg::*;
  slot_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  src_t src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][REG_AW-1:0] id_src, exe_src, mem_src;
  logic [1:0] id_en, exe_en, mem_en;
  logic [1:0] id_hit, mem_hit, wb_hit;
  logic hazard, bubble;
  assign id_src = {bus.id_src2, bus.id_src1};
  assign id_en = {bus.id_two_src, bus.id_src1_en};
  assign exe_src = {src_q.src2, src_q.src1};
  assign exe_en = {src_q.src2_en, src_q.src1_en};
`ifdef FWD_HAZARD_FORWARDING_EN
  assign mem_src = exe_src;
  assign mem_en = exe_en;
`else
  assign mem_src = id_src;
  assign mem_en = id_en;
`endif
  for (genvar i = 0; i < 2; i++) begin : g_match
    fwd_match #(.REG_AW(REG_AW)) u_exe (
      .valid(exe_q.valid), .wb_en(exe_q.wb_en), .dest(exe_q.dest),
      .src(id_src[i]), .en(id_en[i]), .match(id_hit[i])
    );
    fwd_match #(.REG_AW(REG_AW)) u_mem (
      .valid(mem_q.valid), .wb_en(mem_q.wb_en), .dest(mem_q.dest),
      .src(mem_src[i]), .en(mem_en[i]), .match(mem_hit[i])
    );
    fwd_match #(.REG_AW(REG_AW)) u_wb (
      .valid(wb_q.valid), .wb_en(wb_q.wb_en), .dest(wb_q.dest),
      .src(exe_src[i]), .en(exe_en[i]), .match(wb_hit[i])
    );
  end
`ifdef FWD_HAZARD_FORWARDING_EN
  assign hazard = bus.id_valid && !bus.flush && exe_q.mem_r_en && |id_hit;
  assign bus.sel_src1 = mem_hit[0] ? SEL_MEM : wb_hit[0] ? SEL_WB : SEL_REG;
  assign bus.sel_src2 = mem_hit[1] ? SEL_MEM : wb_hit[1] ? SEL_WB : SEL_REG;
  a_no_load_fwd: assert property (@(posedge clk) disable iff (rst) !(|mem_hit && mem_q.mem_r_en));
`else
  assign hazard = bus.id_valid && !bus.flush && (|id_hit || |mem_hit);
  assign bus.sel_src1 = SEL_REG;
  assign bus.sel_src2 = SEL_REG;
`endif
  assign bus.hazard = hazard;
  assign bus.stall_cnt = cnt_q;
  // advance the shadow pipe (bubble on stall/flush/empty ID) unless frozen; count stall cycles
  always_comb begin
    bubble = hazard || bus.flush || !bus.id_valid;
    exe_d = bus.freeze ? exe_q : bubble ? '0 : slot_t'{1'b1, bus.id_dest, bus.id_wb_en, bus.id_mem_r_en};
    src_d = bus.freeze ? src_q : bubble ? '0 : src_t'{bus.id_src1, bus.id_src1_en, bus.id_src2, bus.id_two_src};
    mem_d = bus.freeze ? mem_q : exe_q;
    wb_d = bus.freeze ? wb_q : mem_q;
    cnt_d = (!bus.freeze && hazard && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      src_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      src_q <= src_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
